fma_line_collector: RTL and testbench
=====================================

// Module: fma_line_collector
// PURPOSE
// - Packs results from FMA_COUNT fma lanes into LINE_WIDTH-bit lines and queues them in a DEPTH-line FIFO.
// - The FIFO has a valid/ready drain toward memory write-back.
// - It is the parametrised successor to the fixed two-lane write buffer; new over that block: any lane count,
//   multi-set lines, backpressure, flush, and sticky error flags.
// PARAMETERS
// FMA_COUNT   2   number of fma lanes feeding the block
// WORD_WIDTH  16  bits per fma result
// LINE_WIDTH  96  bits per output line; must be a multiple of WORD_WIDTH*FMA_COUNT
// DEPTH       4   FIFO depth in lines; power of two, >=2
// PORTS
// clk_in             in   1                     single system clock
// rst_in             in   1                     synchronous, active-low reset
// fma_out_in         in   WORD_WIDTH*FMA_COUNT  lane results; lane 0 in the MSBs
// fma_valid_in       in   FMA_COUNT             per-lane valid, one bit per lane (lane 0 = MSB)
// flush_in           in   1                     single-cycle pulse: push the partial line
// line_out           out  LINE_WIDTH            head-of-FIFO line
// line_valid_out     out  1                     line_out holds a valid line
// line_ready_in      in   1                     consumer accepts line_out this cycle
// fill_level_out     out  $clog2(DEPTH)+1       number of lines in the FIFO
// overflow_out       out  1                     sticky: a completed line was dropped
// collision_out      out  1                     sticky: a lane re-fired before its set completed
// idle_out           out  1                     no held lanes, no partial line, FIFO empty
// BEHAVIOUR
// - Derived constants: SETS = LINE_WIDTH/(WORD_WIDTH*FMA_COUNT); a "set" is one word from every lane.
// - Reset (rst_in==0 at a clock edge) clears all state: hold regs, set pointer, flush_pending, FIFO, flags.
//   After reset: line_valid_out=0, line_out=0, fill_level_out=0, overflow_out=0, collision_out=0, idle_out=1.
//   A reset mid-line discards all partial data.
// - Lane hold: each lane has a WORD_WIDTH register plus a held bit. A valid on a non-held lane captures
//   the word and sets held.
// - Set completion is combinational, in the same cycle: all lanes satisfy (held | valid).
//   - Each word is taken from the hold reg if held, else from the live input.
//   - The words are written into set slot ptr; all held bits clear and ptr increments.
//   - Slot 0 occupies the line MSBs; lane order within a set is lane 0 first (MSB).
// - Collision: a lane that is held, receives valid, and no set completes that cycle.
//   - The new word is discarded and collision_out is set (sticky).
// - Line completion: a set lands in slot SETS-1 -> the line pushes to the FIFO in the next cycle and
//   ptr wraps to 0.
// - Flush:
//   - Nothing held and ptr>0: push the line with slots >=ptr zero-filled, then ptr=0.
//   - Some lanes held: set flush_pending; the next set completion then pushes the line zero-padded
//     after that set.
//   - ptr==0 and nothing held: no-op.
//   - Flush in the same cycle as a natural line completion: one push only.
// - FIFO:
//   - Push and pop happen on the same edge. Pop occurs when line_valid_out & line_ready_in.
//   - Push when full: accepted if a pop occurs the same cycle. Otherwise the line is dropped and
//     overflow_out is set (sticky).
//   - line_out/line_valid_out are registered from the head entry.
//   - A line pushed into an empty FIFO is visible on line_out one cycle after the push edge.
//   - line_out is held stable while line_valid_out & !line_ready_in.
//   - fill_level_out counts entries and equals DEPTH when full.
// - Latency: completing set accepted at edge N -> line_valid_out=1 after edge N+2, with an empty FIFO
//   and no backpressure.
// - Width rule: no arithmetic on data; words are passed bit-exact.
// STRUCTURE
// - gpu_pkg: WORD_WIDTH, FMA_COUNT, LINE_WIDTH defaults, and a function sets_per_line().
// - One sub-module: gpu_sync_fifo #(WIDTH, DEPTH), single-clock, active-low sync reset, registered head,
//   push_ok/full/count.
// - Top level holds the lane hold regs, the set pointer, flush_pending, and the line assembly register.
// - Elaboration-time $error if LINE_WIDTH % (WORD_WIDTH*FMA_COUNT) != 0 or DEPTH is not a power of two.
// TESTING
// 1 Defaults, ready=1; three cycles with both lanes valid, words A1/B1, A2/B2, A3/B3
//   -> one line {A1,B1,A2,B2,A3,B3}, valid 2 cycles after the third set.
// 2 Lane0 valid cyc0, lane1 valid cyc3 (x3 sets)
//   -> same packing; collision_out stays 0.
// 3 Lane0 valid cyc0 and cyc1 with no lane1
//   -> collision_out=1, the cyc0 word is kept.
// 4 ready=0, push 5 lines with DEPTH=4
//   -> fill_level_out=4, overflow_out=1, first 4 lines are drained in order once ready=1.
// 5 One set, then flush_in
//   -> line {A,B,0,0,0,0}, ptr=0, idle_out=1 after the drain.
// 6 Reset low mid-line with FIFO=2
//   -> all outputs return to reset values; the next full line packs from slot 0.
//   Repeat tests 1-6 with FMA_COUNT=4, LINE_WIDTH=128.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared defaults and helpers for the GPU write-back path.
package gpu_pkg;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_FMA_COUNT  = 2;
  localparam int DEF_LINE_WIDTH = 96;
  localparam int DEF_DEPTH      = 4;

  // Number of lane sets (one word from every lane) that fit in one line.
  function automatic int sets_per_line(input int line_w, input int word_w, input int lanes);
    return line_w / (word_w * lanes);
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Single-clock line FIFO with a registered head; a push is visible on head one cycle after its edge.
module gpu_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head,
  output logic                     head_vld,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]    cnt_left;
  logic             pop, full, wr;

  assign pop      = head_vld & pop_ready;
  assign full     = (count == CW'(DEPTH));
  assign push_ok  = ~full | pop;
  assign wr       = push & push_ok;
  assign rd_nxt   = rd_ptr + AW'(pop);
  // Entries that remain after this pop, excluding any line written on this edge.
  assign cnt_left = count - CW'(pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      head_vld <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_nxt;
      count    <= cnt_left + CW'(wr);
      head_vld <= (cnt_left != '0);
      head     <= (cnt_left != '0) ? mem[rd_nxt] : '0;
    end
  end

endmodule

// File: rtl/fma_line_collector.sv
// Collects per-lane FMA results into sets, packs sets into lines and queues lines for write-back.
module fma_line_collector
  import gpu_pkg::*;
#(
  parameter int FMA_COUNT  = DEF_FMA_COUNT,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [WORD_WIDTH*FMA_COUNT-1:0]  fma_out_in,
  input  logic [FMA_COUNT-1:0]             fma_valid_in,
  input  logic                             flush_in,
  output logic [LINE_WIDTH-1:0]            line_out,
  output logic                             line_valid_out,
  input  logic                             line_ready_in,
  output logic [$clog2(DEPTH):0]           fill_level_out,
  output logic                             overflow_out,
  output logic                             collision_out,
  output logic                             idle_out
);
  localparam int SET_W = WORD_WIDTH * FMA_COUNT;
  localparam int SETS  = sets_per_line(LINE_WIDTH, WORD_WIDTH, FMA_COUNT);
  localparam int PW    = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  if (LINE_WIDTH % SET_W != 0) begin : g_bad_width
    $error("LINE_WIDTH must be a multiple of WORD_WIDTH*FMA_COUNT");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  // Packed lane order matches fma_out_in, so lane 0 sits in the MSBs throughout.
  typedef logic [FMA_COUNT-1:0][WORD_WIDTH-1:0] set_t;

  set_t                        live, hold_q, set_w;
  logic [FMA_COUNT-1:0]        held_q;
  logic [PW-1:0]               ptr_q;
  logic                        flush_pend_q;
  logic [SETS-1:0][SET_W-1:0]  line_q, line_nxt;
  logic                        push_vld_q;
  logic [LINE_WIDTH-1:0]       push_line_q;
  logic                        overflow_q, collision_q;
  logic                        set_done, any_held, last_slot, close_line, push_ok;
  logic [CW-1:0]               fifo_count;

  assign live      = set_t'(fma_out_in);
  assign set_done  = &(held_q | fma_valid_in);
  assign any_held  = |held_q;
  assign last_slot = (ptr_q == PW'(SETS - 1));

  always_comb begin
    set_w = live;
    for (int j = 0; j < FMA_COUNT; j++)
      if (held_q[j]) set_w[j] = hold_q[j];
  end

  // Slot 0 is the top element of line_q so the first set lands in the line MSBs.
  always_comb begin
    line_nxt = line_q;
    if (set_done) line_nxt[SETS-1-int'(ptr_q)] = set_w;
  end

  // A set completing alongside a flush (live or pending) closes the line only once.
  assign close_line = set_done ? (last_slot | flush_in | flush_pend_q)
                               : (flush_in & ~any_held & (ptr_q != '0));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hold_q       <= '0;
      held_q       <= '0;
      ptr_q        <= '0;
      flush_pend_q <= 1'b0;
      line_q       <= '0;
      push_vld_q   <= 1'b0;
      push_line_q  <= '0;
      overflow_q   <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      push_vld_q <= close_line;
      if (close_line) push_line_q <= line_nxt;

      // Clearing the assembly register on close keeps unfilled slots zero for flushes.
      if (close_line) begin
        line_q       <= '0;
        ptr_q        <= '0;
        flush_pend_q <= 1'b0;
      end else if (set_done) begin
        line_q <= line_nxt;
        ptr_q  <= ptr_q + PW'(1);
      end else if (flush_in & any_held) begin
        flush_pend_q <= 1'b1;
      end

      if (set_done) begin
        held_q <= '0;
      end else begin
        for (int j = 0; j < FMA_COUNT; j++)
          if (fma_valid_in[j] & ~held_q[j]) begin
            held_q[j] <= 1'b1;
            hold_q[j] <= live[j];
          end
      end

      if (~set_done & |(held_q & fma_valid_in)) collision_q <= 1'b1;
      if (push_vld_q & ~push_ok)                overflow_q  <= 1'b1;
    end
  end

  gpu_sync_fifo #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .push      (push_vld_q),
    .push_data (push_line_q),
    .pop_ready (line_ready_in),
    .head      (line_out),
    .head_vld  (line_valid_out),
    .push_ok   (push_ok),
    .count     (fifo_count)
  );

  assign fill_level_out = fifo_count;
  assign overflow_out   = overflow_q;
  assign collision_out  = collision_q;
  assign idle_out       = ~any_held & (ptr_q == '0) & ~flush_pend_q & ~push_vld_q & (fifo_count == '0);

endmodule

// File: tb/tb_fma_line_collector.sv
// Random and directed stimulus for two collector configurations, checked against a queue-based model.
module tb_fma_line_collector;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  fma_out;
  logic [3:0]   fma_valid;
  logic         flush, ready;

  logic [95:0]  a_line;  logic a_vld, a_ovf, a_col, a_idle;  logic [2:0] a_fill;
  logic [127:0] b_line;  logic b_vld, b_ovf, b_col, b_idle;  logic [2:0] b_fill;

  always #5 clk = ~clk;

  fma_line_collector #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96), .DEPTH(DEPTH)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .fma_out_in(fma_out[31:0]), .fma_valid_in(fma_valid[1:0]),
    .flush_in(flush), .line_out(a_line), .line_valid_out(a_vld), .line_ready_in(ready),
    .fill_level_out(a_fill), .overflow_out(a_ovf), .collision_out(a_col), .idle_out(a_idle));

  fma_line_collector #(.FMA_COUNT(4), .WORD_WIDTH(16), .LINE_WIDTH(128), .DEPTH(DEPTH)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .fma_out_in(fma_out), .fma_valid_in(fma_valid),
    .flush_in(flush), .line_out(b_line), .line_valid_out(b_vld), .line_ready_in(ready),
    .fill_level_out(b_fill), .overflow_out(b_ovf), .collision_out(b_col), .idle_out(b_idle));

  int total = 0, bad = 0;
  int cfg, nl, sets, lw;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cfg=%0d got=%h exp=%h", tag, cfg, got, exp);
    end
  endtask

  function automatic logic [127:0] o_line();
    return (cfg == 0) ? {32'b0, a_line} : b_line;
  endfunction
  function automatic logic o_vld();  return (cfg == 0) ? a_vld  : b_vld;  endfunction
  function automatic logic [2:0] o_fill(); return (cfg == 0) ? a_fill : b_fill; endfunction
  function automatic logic o_ovf();  return (cfg == 0) ? a_ovf  : b_ovf;  endfunction
  function automatic logic o_col();  return (cfg == 0) ? a_col  : b_col;  endfunction
  function automatic logic o_idle(); return (cfg == 0) ? a_idle : b_idle; endfunction

  // Behavioural model: lanes, a word list for the open line, and the FIFO as a queue of lines.
  bit           m_held [4];
  logic [15:0]  m_hw   [4];
  logic [15:0]  m_words[8];
  int           m_ptr;
  bit           m_fpend, m_pushp, m_vld, m_ovf, m_col;
  logic [127:0] m_pushl, m_line;
  logic [127:0] m_q[$];

  function automatic logic [127:0] pack(input logic [15:0] w[$]);
    logic [127:0] l = '0;
    for (int k = 0; k < w.size(); k++) l[lw-16-16*k +: 16] = w[k];
    return l;
  endfunction

  task automatic m_close();
    logic [15:0] w[$];
    for (int k = 0; k < m_ptr*nl; k++) w.push_back(m_words[k]);
    m_pushl = pack(w);
    m_pushp = 1; m_ptr = 0; m_fpend = 0;
  endtask

  task automatic model_step();
    bit done, anyh, pop;
    int nb;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_held[i] = 0; m_hw[i] = '0; end
      m_ptr = 0; m_fpend = 0; m_pushp = 0; m_vld = 0; m_ovf = 0; m_col = 0;
      m_line = '0; m_q.delete();
      return;
    end
    pop = m_vld && ready;
    if (pop) void'(m_q.pop_front());
    nb = m_q.size();
    if (m_pushp) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pushl);
      else m_ovf = 1;
    end
    m_pushp = 0;
    m_vld  = (nb > 0);
    m_line = (nb > 0) ? m_q[0] : '0;
    done = 1; anyh = 0;
    for (int i = 0; i < nl; i++) begin
      if (!(m_held[i] || fma_valid[nl-1-i])) done = 0;
      anyh |= m_held[i];
    end
    if (done) begin
      for (int i = 0; i < nl; i++) begin
        m_words[m_ptr*nl+i] = m_held[i] ? m_hw[i] : fma_out[(nl-1-i)*16 +: 16];
        m_held[i] = 0;
      end
      m_ptr++;
      if (m_ptr == sets || flush || m_fpend) m_close();
    end else begin
      for (int i = 0; i < nl; i++)
        if (fma_valid[nl-1-i]) begin
          if (m_held[i]) m_col = 1;
          else begin m_held[i] = 1; m_hw[i] = fma_out[(nl-1-i)*16 +: 16]; end
        end
      if (flush) begin
        if (anyh) m_fpend = 1;
        else if (m_ptr > 0) m_close();
      end
    end
  endtask

  function automatic bit m_idle();
    bit h = 0;
    for (int i = 0; i < nl; i++) h |= m_held[i];
    return !h && m_ptr == 0 && !m_fpend && !m_pushp && m_q.size() == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("line_valid", o_vld(), m_vld);
    chk("line_out", o_line(), m_line);
    chk("fill_level", o_fill(), m_q.size());
    chk("overflow", o_ovf(), m_ovf);
    chk("collision", o_col(), m_col);
    chk("idle", o_idle(), m_idle());
  endtask

  task automatic set_lane(input int i, input bit v, input logic [15:0] w);
    fma_valid[nl-1-i] = v;
    fma_out[(nl-1-i)*16 +: 16] = w;
  endtask

  task automatic clear_in();
    fma_valid = '0; fma_out = {$urandom, $urandom}; flush = 0;
  endtask

  logic [15:0] ew[$];

  task automatic drive_set();
    logic [15:0] w;
    for (int i = 0; i < nl; i++) begin
      w = 16'($urandom);
      set_lane(i, 1, w);
      ew.push_back(w);
    end
    tick();
    clear_in();
  endtask

  task automatic wait_line(input string tag, input logic [127:0] exp);
    int n = 0;
    while (!o_vld() && n < 12) begin tick(); n++; end
    chk({tag, "_seen"}, o_vld(), 1'b1);
    chk(tag, o_line(), exp);
    tick();
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst_vld", o_vld(), 1'b0);
    chk("rst_line", o_line(), 128'b0);
    chk("rst_fill", o_fill(), 3'd0);
    chk("rst_flags", {o_ovf(), o_col(), o_idle()}, 3'b001);
  endtask

  task automatic run_cfg(input int c);
    logic [15:0] x, y;
    logic [127:0] l5[$];
    cfg = c;
    nl   = (c == 0) ? 2 : 4;
    lw   = (c == 0) ? 96 : 128;
    sets = lw / (16 * nl);
    ready = 1;
    do_reset();

    // Full sets back to back; line appears two edges after the last set.
    ew.delete();
    for (int s = 0; s < sets; s++) drive_set();
    tick(); chk("t1_lat1", o_vld(), 1'b0);
    tick(); chk("t1_lat2", o_vld(), 1'b1);
    chk("t1_line", o_line(), pack(ew));
    tick();

    // Lane 0 early, the rest three cycles later.
    ew.delete();
    for (int s = 0; s < sets; s++) begin
      x = 16'($urandom); set_lane(0, 1, x); ew.push_back(x); tick(); clear_in();
      tick(); tick();
      for (int i = 1; i < nl; i++) begin
        y = 16'($urandom); set_lane(i, 1, y); ew.push_back(y);
      end
      tick(); clear_in();
    end
    wait_line("t2_line", pack(ew));
    chk("t2_col", o_col(), 1'b0);

    // Lane 0 re-fires while held: the first word survives.
    do_reset();
    ew.delete();
    x = 16'($urandom); y = ~x;
    set_lane(0, 1, x); ew.push_back(x); tick(); clear_in();
    set_lane(0, 1, y); tick(); clear_in();
    chk("t3_col", o_col(), 1'b1);
    for (int i = 1; i < nl; i++) begin
      y = 16'($urandom); set_lane(i, 1, y); ew.push_back(y);
    end
    tick(); clear_in();
    for (int s = 1; s < sets; s++) drive_set();
    wait_line("t3_line", pack(ew));

    // Backpressure: five lines into a four-deep FIFO.
    do_reset();
    ready = 0;
    for (int k = 0; k < 5; k++) begin
      ew.delete();
      for (int s = 0; s < sets; s++) drive_set();
      l5.push_back(pack(ew));
    end
    tick(); tick();
    chk("t4_fill", o_fill(), 3'd4);
    chk("t4_ovf", o_ovf(), 1'b1);
    ready = 1;
    for (int k = 0; k < 4; k++) wait_line("t4_drain", l5[k]);
    tick();
    chk("t4_empty", o_fill(), 3'd0);

    // One set then flush: zero-padded line.
    do_reset();
    ew.delete();
    drive_set();
    flush = 1; tick(); flush = 0;
    wait_line("t5_line", pack(ew));
    tick();
    chk("t5_idle", o_idle(), 1'b1);

    // Reset with two lines queued and a partial line open.
    do_reset();
    ready = 0;
    for (int k = 0; k < 2; k++) for (int s = 0; s < sets; s++) drive_set();
    drive_set();
    set_lane(0, 1, 16'($urandom)); tick(); clear_in();
    tick();
    chk("t6_fill", o_fill(), 3'd2);
    do_reset();
    ready = 1;
    ew.delete();
    for (int s = 0; s < sets; s++) drive_set();
    wait_line("t6_line", pack(ew));

    // Random traffic including flushes, backpressure and occasional reset.
    for (int c2 = 0; c2 < 600; c2++) begin
      for (int i = 0; i < nl; i++) set_lane(i, bit'($urandom_range(0, 2) != 0), 16'($urandom));
      ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 14) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      rst_n = 1;
    end
    clear_in();
  endtask

  initial begin
    rst_n = 0; ready = 1; fma_valid = '0; fma_out = '0; flush = 0;
    cfg = 0; nl = 2; lw = 96; sets = 3;
    run_cfg(0);
    run_cfg(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
